pair_link_monitor: RTL and testbench

Link-pulse monitor for the two received TIA-568B pair signals (pair 1-2 and pair 3-6) after post-LNA checking. Synchronises both pair signals into the 100 MHz domain, counts transitions per pair over fixed observation windows, and runs a qualification state machine that declares the link up, down, or single-pair faulted. Sits directly downstream of the post-LNA pair check and feeds link status to the link-power controller.

---
 rtl/pair_link_monitor_if.sv | 14 +
 rtl/pair_link_monitor.sv | 117 +++++++++++
 tb/tb_pair_link_monitor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pair_link_monitor_if.sv
// pair_link_monitor_if: pair inputs and link status outputs of pair_link_monitor
// Pair12/Pair36 : asynchronous pair signals into the monitor
// LinkUp/LinkState/WindowStrobe/EdgeCount12/EdgeCount36 : link status out of the monitor
interface pair_link_monitor_if;
  logic       Pair12;
  logic       Pair36;
  logic       LinkUp;
  logic [1:0] LinkState;
  logic       WindowStrobe;
  logic [7:0] EdgeCount12;
  logic [7:0] EdgeCount36;
  modport master(output Pair12, Pair36, input LinkUp, LinkState, WindowStrobe, EdgeCount12, EdgeCount36);
  modport slave(input Pair12, Pair36, output LinkUp, LinkState, WindowStrobe, EdgeCount12, EdgeCount36);
endinterface

// File: rtl/pair_link_monitor.sv
// pair_link_monitor: counts pair transitions per window and qualifies link up/down/fault
// Clock100Mhz : system clock, Reset : asynchronous active-high reset
// link        : pair inputs, link state, window strobe and per-window edge counts
module pair_link_monitor #(
  parameter int WINDOW_CYCLES = 1600000,
  parameter int MIN_EDGES     = 2,
  parameter int UP_WINDOWS    = 3,
  parameter int DOWN_WINDOWS  = 2
) (
  input logic Clock100Mhz,
  input logic Reset,
  pair_link_monitor_if.slave link
);
  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam int GW = $clog2(UP_WINDOWS + 1);
  localparam int BW = $clog2(DOWN_WINDOWS + 1);
  typedef enum logic [1:0] {DOWN, ACQUIRE, UP, FAULT} state_t;
  logic [1:0] sync12_q, sync12_d, sync36_q, sync36_d;
  logic dly12_q, dly12_d, dly36_q, dly36_d;
  logic [WW-1:0] win_q, win_d;
  logic [7:0] cnt12_q, cnt12_d, cnt36_q, cnt36_d;
  logic [7:0] ec12_q, ec12_d, ec36_q, ec36_d;
  logic strobe_q, strobe_d, link_up_q, link_up_d;
  state_t state_q, state_d;
  logic [GW-1:0] good_run_q, good_run_d;
  logic [BW-1:0] bad_run_q, bad_run_d;
  logic term, e12, e36, act12, act36, good, silent, onesided;
  logic [7:0] n12, n36;
  always_comb begin
    sync12_d = {sync12_q[0], link.Pair12};
    sync36_d = {sync36_q[0], link.Pair36};
    dly12_d = sync12_q[1];
    dly36_d = sync36_q[1];
    e12 = sync12_q[1] ^ dly12_q;
    e36 = sync36_q[1] ^ dly36_q;
    term = win_q == WW'(WINDOW_CYCLES - 1);
    win_d = term ? '0 : win_q + WW'(1);
    // Counts including this cycle's edge, so a terminal-cycle edge lands in the closing window.
    n12 = cnt12_q + 8'(e12 & ~&cnt12_q);
    n36 = cnt36_q + 8'(e36 & ~&cnt36_q);
    cnt12_d = term ? '0 : n12;
    cnt36_d = term ? '0 : n36;
    ec12_d = term ? n12 : ec12_q;
    ec36_d = term ? n36 : ec36_q;
    strobe_d = term;
    act12 = int'(n12) >= MIN_EDGES;
    act36 = int'(n36) >= MIN_EDGES;
    good = act12 && act36;
    silent = n12 == 8'd0 && n36 == 8'd0;
    onesided = (act12 && n36 == 8'd0) || (act36 && n12 == 8'd0);
    state_d = state_q;
    good_run_d = good_run_q;
    bad_run_d = bad_run_q;
    if (term)
      case (state_q)
        DOWN: if (good) begin
          state_d = ACQUIRE;
          good_run_d = GW'(1);
        end
        ACQUIRE: if (!good) begin
          state_d = DOWN;
          good_run_d = '0;
        end else if (int'(good_run_q) + 1 >= UP_WINDOWS) begin
          state_d = UP;
          bad_run_d = '0;
        end else good_run_d = good_run_q + GW'(1);
        UP: if (good) bad_run_d = '0;
        else if (onesided) begin
          state_d = FAULT;
          bad_run_d = '0;
        end else if (int'(bad_run_q) + 1 >= DOWN_WINDOWS) state_d = DOWN;
        else bad_run_d = bad_run_q + BW'(1);
        default: if (good) begin
          state_d = ACQUIRE;
          good_run_d = GW'(1);
        end else if (!onesided || silent) state_d = DOWN;
      endcase
    link_up_d = state_d == UP;
  end
  always_ff @(posedge Clock100Mhz or posedge Reset)
    if (Reset) begin
      sync12_q <= '0;
      sync36_q <= '0;
      dly12_q <= 1'b0;
      dly36_q <= 1'b0;
      win_q <= '0;
      cnt12_q <= '0;
      cnt36_q <= '0;
      ec12_q <= '0;
      ec36_q <= '0;
      strobe_q <= 1'b0;
      link_up_q <= 1'b0;
      state_q <= DOWN;
      good_run_q <= '0;
      bad_run_q <= '0;
    end else begin
      sync12_q <= sync12_d;
      sync36_q <= sync36_d;
      dly12_q <= dly12_d;
      dly36_q <= dly36_d;
      win_q <= win_d;
      cnt12_q <= cnt12_d;
      cnt36_q <= cnt36_d;
      ec12_q <= ec12_d;
      ec36_q <= ec36_d;
      strobe_q <= strobe_d;
      link_up_q <= link_up_d;
      state_q <= state_d;
      good_run_q <= good_run_d;
      bad_run_q <= bad_run_d;
    end
  assign link.LinkUp = link_up_q;
  assign link.LinkState = state_q;
  assign link.WindowStrobe = strobe_q;
  assign link.EdgeCount12 = ec12_q;
  assign link.EdgeCount36 = ec36_q;
endmodule

// File: tb/tb_pair_link_monitor.sv
// tb_pair_link_monitor: directed checks of windowing, saturation and link qualification
module tb_pair_link_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pair_link_monitor_if m();
  pair_link_monitor_if s();
  pair_link_monitor #(.WINDOW_CYCLES(100), .MIN_EDGES(2), .UP_WINDOWS(3), .DOWN_WINDOWS(2))
    dut (.Clock100Mhz(clk), .Reset(rst), .link(m));
  pair_link_monitor #(.WINDOW_CYCLES(400), .MIN_EDGES(2), .UP_WINDOWS(3), .DOWN_WINDOWS(2))
    dut_sat (.Clock100Mhz(clk), .Reset(rst), .link(s));

  task automatic wait_strobe(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m.WindowStrobe && k < 300);
    if (!m.WindowStrobe) begin
      total++;
      bad++;
      $display("FAIL strobe_timeout waited=%0d required<300", k);
    end
  endtask

  task automatic win(input int n12, input int n36);
    int k;
    for (int i = 0; i < 5; i++) begin
      if (i < n12) m.Pair12 = ~m.Pair12;
      if (i < n36) m.Pair36 = ~m.Pair36;
      repeat (2) @(negedge clk);
    end
    wait_strobe(k);
  endtask

  task automatic test_reset;
    int k;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    win(4, 4);
    total++; if (m.LinkState !== 2'd1) begin bad++; $display("FAIL pre_reset_state got=%0d want=1", m.LinkState); end
    repeat (20) @(negedge clk);
    m.Pair12 = 1'b1;
    @(negedge clk);
    m.Pair12 = 1'b0;
    m.Pair36 = 1'b1;
    @(negedge clk);
    m.Pair36 = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (m.LinkUp !== 1'b0) begin bad++; $display("FAIL rst_linkup got=%0d want=0", m.LinkUp); end
    total++; if (m.LinkState !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", m.LinkState); end
    total++; if (m.WindowStrobe !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%0d want=0", m.WindowStrobe); end
    total++; if (m.EdgeCount12 !== 8'd0) begin bad++; $display("FAIL rst_ec12 got=%0d want=0", m.EdgeCount12); end
    total++; if (m.EdgeCount36 !== 8'd0) begin bad++; $display("FAIL rst_ec36 got=%0d want=0", m.EdgeCount36); end
    @(negedge clk);
    rst = 1'b0;
    wait_strobe(k);
    total++; if (k !== 100) begin bad++; $display("FAIL first_strobe_cycle got=%0d want=100", k); end
    total++; if (m.EdgeCount12 !== 8'd0) begin bad++; $display("FAIL first_ec12 got=%0d want=0", m.EdgeCount12); end
    total++; if (m.EdgeCount36 !== 8'd0) begin bad++; $display("FAIL first_ec36 got=%0d want=0", m.EdgeCount36); end
    total++; if (m.LinkState !== 2'd0) begin bad++; $display("FAIL first_state got=%0d want=0", m.LinkState); end
    @(negedge clk);
    total++; if (m.WindowStrobe !== 1'b0) begin bad++; $display("FAIL strobe_width got=%0d want=0", m.WindowStrobe); end
  endtask

  task automatic test_link_up;
    win(4, 4);
    total++; if (m.LinkState !== 2'd1) begin bad++; $display("FAIL up_w1_state got=%0d want=1", m.LinkState); end
    win(4, 4);
    total++; if (m.LinkState !== 2'd1) begin bad++; $display("FAIL up_w2_state got=%0d want=1", m.LinkState); end
    win(4, 4);
    total++; if (m.LinkState !== 2'd2) begin bad++; $display("FAIL up_w3_state got=%0d want=2", m.LinkState); end
    total++; if (m.LinkUp !== 1'b1) begin bad++; $display("FAIL up_linkup got=%0d want=1", m.LinkUp); end
    total++; if (m.EdgeCount12 !== 8'd4) begin bad++; $display("FAIL up_ec12 got=%0d want=4", m.EdgeCount12); end
  endtask

  task automatic test_link_drop;
    win(0, 0);
    total++; if (m.LinkState !== 2'd2) begin bad++; $display("FAIL drop_w1_state got=%0d want=2", m.LinkState); end
    total++; if (m.LinkUp !== 1'b1) begin bad++; $display("FAIL drop_w1_linkup got=%0d want=1", m.LinkUp); end
    win(0, 0);
    total++; if (m.LinkState !== 2'd0) begin bad++; $display("FAIL drop_w2_state got=%0d want=0", m.LinkState); end
    total++; if (m.LinkUp !== 1'b0) begin bad++; $display("FAIL drop_w2_linkup got=%0d want=0", m.LinkUp); end
  endtask

  task automatic test_fault;
    repeat (3) win(4, 4);
    total++; if (m.LinkState !== 2'd2) begin bad++; $display("FAIL fault_pre_state got=%0d want=2", m.LinkState); end
    win(4, 0);
    total++; if (m.LinkState !== 2'd3) begin bad++; $display("FAIL fault_state got=%0d want=3", m.LinkState); end
    total++; if (m.EdgeCount12 !== 8'd4) begin bad++; $display("FAIL fault_ec12 got=%0d want=4", m.EdgeCount12); end
    total++; if (m.EdgeCount36 !== 8'd0) begin bad++; $display("FAIL fault_ec36 got=%0d want=0", m.EdgeCount36); end
    total++; if (m.LinkUp !== 1'b0) begin bad++; $display("FAIL fault_linkup got=%0d want=0", m.LinkUp); end
    win(4, 4);
    total++; if (m.LinkState !== 2'd1) begin bad++; $display("FAIL fault_good_state got=%0d want=1", m.LinkState); end
    win(4, 4);
    total++; if (m.LinkState !== 2'd1) begin bad++; $display("FAIL reacq_w2_state got=%0d want=1", m.LinkState); end
    win(4, 4);
    total++; if (m.LinkState !== 2'd2) begin bad++; $display("FAIL reacq_w3_state got=%0d want=2", m.LinkState); end
    win(4, 0);
    total++; if (m.LinkState !== 2'd3) begin bad++; $display("FAIL fault2_state got=%0d want=3", m.LinkState); end
    win(0, 0);
    total++; if (m.LinkState !== 2'd0) begin bad++; $display("FAIL fault_silent_state got=%0d want=0", m.LinkState); end
  endtask

  task automatic test_terminal_edge;
    int k;
    repeat (97) @(negedge clk);
    m.Pair12 = ~m.Pair12;
    wait_strobe(k);
    total++; if (k !== 3) begin bad++; $display("FAIL term_strobe_gap got=%0d want=3", k); end
    total++; if (m.EdgeCount12 !== 8'd1) begin bad++; $display("FAIL term_ec12_closing got=%0d want=1", m.EdgeCount12); end
    total++; if (m.EdgeCount36 !== 8'd0) begin bad++; $display("FAIL term_ec36_closing got=%0d want=0", m.EdgeCount36); end
    wait_strobe(k);
    total++; if (k !== 100) begin bad++; $display("FAIL strobe_period got=%0d want=100", k); end
    total++; if (m.EdgeCount12 !== 8'd0) begin bad++; $display("FAIL term_ec12_next got=%0d want=0", m.EdgeCount12); end
  endtask

  task automatic test_saturation;
    int k = 0;
    while (!s.WindowStrobe && k < 1000) begin
      @(negedge clk);
      k++;
    end
    total++; if (s.WindowStrobe !== 1'b1) begin bad++; $display("FAIL sat_sync_strobe got=%0d want=1", s.WindowStrobe); end
    for (int i = 0; i < 300; i++) begin
      s.Pair12 = ~s.Pair12;
      if (i < 10 && i % 2 == 0) s.Pair36 = ~s.Pair36;
      @(negedge clk);
    end
    k = 0;
    while (!s.WindowStrobe && k < 500) begin
      @(negedge clk);
      k++;
    end
    total++; if (s.WindowStrobe !== 1'b1) begin bad++; $display("FAIL sat_strobe got=%0d want=1", s.WindowStrobe); end
    total++; if (s.EdgeCount12 !== 8'd255) begin bad++; $display("FAIL sat_ec12 got=%0d want=255", s.EdgeCount12); end
    total++; if (s.EdgeCount36 !== 8'd5) begin bad++; $display("FAIL sat_ec36 got=%0d want=5", s.EdgeCount36); end
    total++; if (s.LinkState !== 2'd1) begin bad++; $display("FAIL sat_good_state got=%0d want=1", s.LinkState); end
  endtask

  initial begin
    m.Pair12 = 1'b0;
    m.Pair36 = 1'b0;
    s.Pair12 = 1'b0;
    s.Pair36 = 1'b0;
    test_reset;
    test_link_up;
    test_link_drop;
    test_fault;
    test_terminal_edge;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
